// File: rtl/wb_queue_pkg.sv
// Shared core parameters and the write-back queue entry type.
package wb_queue_pkg;

   localparam int WORD_SIZE     = 32;
   localparam int REG_INDEX     = 5;
   localparam int REG_FILE_SIZE = 32;
   localparam int WB_DEPTH      = 4;

   typedef struct packed {
      logic [REG_INDEX-1:0] num;
      logic [WORD_SIZE-1:0] val;
   } wb_entry_t;

endpackage

// File: rtl/wb_queue_fwd_lookup.sv
// Youngest-match search over the live queue entries for one operand number.
module wb_fwd_lookup
   import wb_queue_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  wb_entry_t              entries [DEPTH],
   input  logic [PTR_W-1:0]       head,
   input  logic [CNT_W-1:0]       count,
   input  logic [REG_INDEX-1:0]   look_num,
   output logic                   hit,
   output logic [WORD_SIZE-1:0]   val
);

   // Walk oldest to youngest so a later (younger) match overrides earlier ones.
   always_comb begin
      hit = 1'b0;
      val = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CNT_W'(k) < count) && (entries[head + PTR_W'(k)].num == look_num)) begin
            hit = 1'b1;
            val = entries[head + PTR_W'(k)].val;
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers results for the register file and forwards
// the youngest queued value for each of three operand reads.
module wb_queue
   import wb_queue_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [REG_INDEX-1:0]  in_num,
   input  logic [WORD_SIZE-1:0]  in_val,
   output logic                  in_ready,
   input  logic                  hold,
   output logic [REG_INDEX-1:0]  set_num,
   output logic [WORD_SIZE-1:0]  set_val,
   output logic                  set_enable,
   input  logic [REG_INDEX-1:0]  look_num1,
   input  logic [REG_INDEX-1:0]  look_num2,
   input  logic [REG_INDEX-1:0]  look_num3,
   output logic                  fwd_hit1,
   output logic                  fwd_hit2,
   output logic                  fwd_hit3,
   output logic [WORD_SIZE-1:0]  fwd_val1,
   output logic [WORD_SIZE-1:0]  fwd_val2,
   output logic [WORD_SIZE-1:0]  fwd_val3,
   output logic [CNT_W-1:0]      count,
   output logic                  empty,
   output logic                  full
);

   wb_entry_t        entries_q [DEPTH];
   wb_entry_t        entries_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             enq;
   logic             deq;

   // in_ready depends only on stored occupancy, never on a same-cycle dequeue.
   always_comb begin
      full       = (count_q == CNT_W'(DEPTH));
      empty      = (count_q == '0);
      in_ready   = !full;
      enq        = in_valid && in_ready;
      set_enable = !empty && !hold;
      deq        = set_enable;
      set_num    = empty ? '0 : entries_q[head_q].num;
      set_val    = empty ? '0 : entries_q[head_q].val;
      count      = count_q;
   end

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (enq) begin
         entries_d[tail_q] = '{num: in_num, val: in_val};
         tail_d            = tail_q + 1'b1;
      end
      if (deq) begin
         head_d = head_q + 1'b1;
      end
      if (enq && !deq) begin
         count_d = count_q + 1'b1;
      end else if (!enq && deq) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         entries_q <= entries_d;
      end
   end

   wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
      .entries (entries_q),
      .head    (head_q),
      .count   (count_q),
      .look_num(look_num1),
      .hit     (fwd_hit1),
      .val     (fwd_val1)
   );

   wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
      .entries (entries_q),
      .head    (head_q),
      .count   (count_q),
      .look_num(look_num2),
      .hit     (fwd_hit2),
      .val     (fwd_val2)
   );

   wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd3 (
      .entries (entries_q),
      .head    (head_q),
      .count   (count_q),
      .look_num(look_num3),
      .hit     (fwd_hit3),
      .val     (fwd_val3)
   );

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue with a negedge-capturing
// register-file model that logs every write in order.
module tb_wb_queue;
   import wb_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  clk;
   logic                  reset_n;
   logic                  in_valid;
   logic [REG_INDEX-1:0]  in_num;
   logic [WORD_SIZE-1:0]  in_val;
   logic                  in_ready;
   logic                  hold;
   logic [REG_INDEX-1:0]  set_num;
   logic [WORD_SIZE-1:0]  set_val;
   logic                  set_enable;
   logic [REG_INDEX-1:0]  look_num1, look_num2, look_num3;
   logic                  fwd_hit1, fwd_hit2, fwd_hit3;
   logic [WORD_SIZE-1:0]  fwd_val1, fwd_val2, fwd_val3;
   logic [CNT_W-1:0]      count;
   logic                  empty;
   logic                  full;

   int checks = 0;
   int errors = 0;

   logic [WORD_SIZE-1:0] regFile [REG_FILE_SIZE];
   logic [REG_INDEX-1:0] logNum [$];
   logic [WORD_SIZE-1:0] logVal [$];

   wb_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_num    (in_num),
      .in_val    (in_val),
      .in_ready  (in_ready),
      .hold      (hold),
      .set_num   (set_num),
      .set_val   (set_val),
      .set_enable(set_enable),
      .look_num1 (look_num1),
      .look_num2 (look_num2),
      .look_num3 (look_num3),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_hit3  (fwd_hit3),
      .fwd_val1  (fwd_val1),
      .fwd_val2  (fwd_val2),
      .fwd_val3  (fwd_val3),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file captures the write port on the falling edge.
   always @(negedge clk) begin
      if (set_enable) begin
         regFile[set_num] <= set_val;
         logNum.push_back(set_num);
         logVal.push_back(set_val);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [REG_INDEX-1:0] n,
                                input logic [WORD_SIZE-1:0] d, input logic h);
      in_valid = v;
      in_num   = n;
      in_val   = d;
      hold     = h;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkLog(input string tag, input int idx,
                           input logic [REG_INDEX-1:0] n, input logic [WORD_SIZE-1:0] d);
      if (idx < logNum.size()) begin
         checkOutput({tag, "_num"}, 32'(logNum[idx]), 32'(n));
         checkOutput({tag, "_val"}, logVal[idx], d);
      end else begin
         checkOutput({tag, "_missing"}, logNum.size(), idx + 1);
      end
   endtask

   task automatic pulseReset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_num    = '0;
      in_val    = '0;
      hold      = 1'b0;
      look_num1 = '0;
      look_num2 = '0;
      look_num3 = '0;
      for (int i = 0; i < REG_FILE_SIZE; i++) regFile[i] = '0;
      #2;

      $display("[TB] reset state");
      checkOutput("rst_set_enable", set_enable, 0);
      checkOutput("rst_set_num", set_num, 0);
      checkOutput("rst_set_val", set_val, 0);
      checkOutput("rst_fwd_hit1", fwd_hit1, 0);
      checkOutput("rst_fwd_hit2", fwd_hit2, 0);
      checkOutput("rst_fwd_hit3", fwd_hit3, 0);
      checkOutput("rst_fwd_val1", fwd_val1, 0);
      checkOutput("rst_empty", empty, 1);
      checkOutput("rst_full", full, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_count", count, 0);

      @(negedge clk);
      reset_n = 1'b1;
      tick();

      $display("[TB] single enqueue and write");
      look_num1 = 5'd3;
      applyStimulus(1'b1, 5'd3, 32'h0000_00AA, 1'b0);
      checkOutput("t1_ready", in_ready, 1);
      checkOutput("t1_no_enable_yet", set_enable, 0);
      checkOutput("t1_offer_not_fwd", fwd_hit1, 0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("t1_enable", set_enable, 1);
      checkOutput("t1_set_num", set_num, 3);
      checkOutput("t1_set_val", set_val, 32'hAA);
      checkOutput("t1_count1", count, 1);
      checkOutput("t1_head_fwd_hit", fwd_hit1, 1);
      checkOutput("t1_head_fwd_val", fwd_val1, 32'hAA);
      tick();
      checkOutput("t1_count0", count, 0);
      checkOutput("t1_empty", empty, 1);
      checkOutput("t1_enable_off", set_enable, 0);
      checkOutput("t1_regfile", regFile[3], 32'hAA);

      $display("[TB] fill under hold then drain");
      logNum.delete();
      logVal.delete();
      look_num2 = 5'd4;
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1);
         checkOutput("t2_ready", in_ready, 1);
         tick();
      end
      applyStimulus(1'b1, 5'd5, 32'h105, 1'b1);
      checkOutput("t2_count4", count, 4);
      checkOutput("t2_full", full, 1);
      checkOutput("t2_not_ready", in_ready, 0);
      checkOutput("t2_hold_enable", set_enable, 0);
      checkOutput("t2_head_num", set_num, 1);
      checkOutput("t2_head_val", set_val, 32'h101);
      checkOutput("t2_fwd_hit2", fwd_hit2, 1);
      checkOutput("t2_fwd_val2", fwd_val2, 32'h104);
      tick();
      checkOutput("t2_stall_count", count, 4);
      applyStimulus(1'b1, 5'd5, 32'h105, 1'b0);
      checkOutput("t2_release_ready", in_ready, 0);
      checkOutput("t2_release_enable", set_enable, 1);
      tick();
      checkOutput("t2_after_deq_count", count, 3);
      checkOutput("t2_after_deq_ready", in_ready, 1);
      checkOutput("t2_after_deq_head", set_num, 2);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("t2_r5_in_count", count, 3);
      checkOutput("t2_r5_in_head", set_num, 3);
      tick();
      tick();
      tick();
      checkOutput("t2_drained", empty, 1);
      checkOutput("t2_log_size", logNum.size(), 5);
      for (int i = 0; i < 5; i++) begin
         checkLog("t2_log", i, 5'(i + 1), 32'h101 + 32'(i));
      end

      $display("[TB] duplicate destination forwarding");
      logNum.delete();
      logVal.delete();
      look_num1 = 5'd7;
      look_num3 = 5'd7;
      applyStimulus(1'b1, 5'd7, 32'h11, 1'b1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("t3_first_val", fwd_val1, 32'h11);
      applyStimulus(1'b1, 5'd7, 32'h22, 1'b1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("t3_hit1", fwd_hit1, 1);
      checkOutput("t3_val1", fwd_val1, 32'h22);
      checkOutput("t3_val3", fwd_val3, 32'h22);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      tick();
      checkOutput("t3_empty", empty, 1);
      checkOutput("t3_log_size", logNum.size(), 2);
      checkLog("t3_log0", 0, 5'd7, 32'h11);
      checkLog("t3_log1", 1, 5'd7, 32'h22);
      checkOutput("t3_regfile", regFile[7], 32'h22);

      $display("[TB] no forwarding of absent or unaccepted entry");
      look_num2 = 5'd9;
      #1;
      checkOutput("t4_miss_hit", fwd_hit2, 0);
      checkOutput("t4_miss_val", fwd_val2, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'd10 + 5'(i), 32'h200 + 32'(i), 1'b1);
         tick();
      end
      applyStimulus(1'b1, 5'd9, 32'h999, 1'b1);
      checkOutput("t4_full_ready", in_ready, 0);
      checkOutput("t4_offer_hit", fwd_hit2, 0);
      checkOutput("t4_offer_val", fwd_val2, 0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
      pulseReset();
      checkOutput("t4_reset_count", count, 0);

      $display("[TB] reset mid-operation");
      logNum.delete();
      logVal.delete();
      look_num1 = 5'd21;
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'd20 + 5'(i), 32'h300 + 32'(i), 1'b1);
         tick();
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("t5_count3", count, 3);
      checkOutput("t5_pre_hit", fwd_hit1, 1);
      #1;
      reset_n = 1'b0;
      #1;
      hold = 1'b0;
      #1;
      checkOutput("t5_rst_count", count, 0);
      checkOutput("t5_rst_enable", set_enable, 0);
      checkOutput("t5_rst_empty", empty, 1);
      checkOutput("t5_rst_fwd", fwd_hit1, 0);
      reset_n = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("t5_no_writes", logNum.size(), 0);
      checkOutput("t5_enable_after", set_enable, 0);

      $display("[TB] back-to-back wrap");
      applyStimulus(1'b1, 5'd16, 32'hC0DE_0000, 1'b0);
      tick();
      for (int i = 1; i <= 2 * DEPTH + 1; i++) begin
         applyStimulus(1'b1, 5'(16 + i), 32'hC0DE_0000 + 32'(i), 1'b0);
         checkOutput("t6_enable", set_enable, 1);
         tick();
         checkOutput("t6_count1", count, 1);
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      checkOutput("t6_empty", empty, 1);
      checkOutput("t6_log_size", logNum.size(), 2 * DEPTH + 2);
      for (int i = 0; i < 2 * DEPTH + 2; i++) begin
         checkLog("t6_log", i, 5'(16 + i), 32'hC0DE_0000 + 32'(i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
